// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Drains a synchronous FIFO in bursts of BURST_LEN words onto a valid/ready
// stream framed with sop/eop. The FIFO has a one-cycle registered read
// latency. A two-entry output buffer absorbs that latency, so sink
// back-pressure never drops or repeats a word.
//
// Optional build macro:
//   FBR_TMO_EN - when defined, a partial burst of min(avail, BURST_LEN) words
//                is launched after TMO_CYC idle cycles with 0 < avail <
//                BURST_LEN. When undefined, only full bursts are launched.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   fifo_rd_en      FIFO read request (never asserted while fifo_empty)
//   fifo_rd_data    FIFO read data, valid the cycle after a read
//   fifo_data_avail FIFO occupancy (P_N+1 bits, registered in the FIFO)
//   fifo_empty      FIFO empty flag (registered in the FIFO)
//   m_valid         stream word valid
//   m_ready         sink accepts the current word
//   m_data          stream word
//   m_sop           first word of a burst
//   m_eop           last word of a burst
//   busy            burst in progress (BURST or DRAIN)
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int F_WIDTH   = 32,
  parameter int F_DEPTH   = 9,
  parameter int P_N       = $clog2(F_DEPTH),
  parameter int BURST_LEN = 4,
  parameter int TMO_CYC   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               fifo_rd_en,
  input  logic [F_WIDTH-1:0] fifo_rd_data,
  input  logic [P_N:0]       fifo_data_avail,
  input  logic               fifo_empty,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [F_WIDTH-1:0] m_data,
  output logic               m_sop,
  output logic               m_eop,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [P_N:0] BLEN_FULL = (P_N+1)'(BURST_LEN);
  localparam logic [P_N:0] ONE       = (P_N+1)'(1);

  if (BURST_LEN < 1 || BURST_LEN > F_DEPTH || TMO_CYC < 1) begin : g_bad_params
    $error("fifo_burst_reader: illegal BURST_LEN/TMO_CYC parameter value");
  end

  logic [1:0]         state;
  logic [P_N:0]       issued;
  logic [P_N:0]       blen;

  // Word requested last cycle, arriving on fifo_rd_data this cycle.
  logic               inflight;
  logic               inflight_sop;
  logic               inflight_eop;

  // Output buffer, entry 0 is the head.
  logic [F_WIDTH-1:0] buf_data [2];
  logic [1:0]         buf_sop;
  logic [1:0]         buf_eop;
  logic [1:0]         buf_cnt;

  logic [2:0]         occupancy;
  logic               head_bypass;
  logic               head_sop;
  logic               head_eop;
  logic               pop;
  logic               store;
  logic               pop_buf;
  logic               full_go;
  logic               tmo_go;

  // Words already buffered plus the one on its way from the FIFO. Reads are
  // only issued while this is below 2, so the buffer cannot overflow.
  assign occupancy  = {1'b0, buf_cnt} + {2'b00, inflight};
  assign fifo_rd_en = (state == BURST) && (issued < blen) && !fifo_empty &&
                      (occupancy < 3'd2);

  // With an empty buffer the arriving word is presented straight from the
  // FIFO data bus, which gives the one-cycle read-to-valid latency.
  assign head_bypass = (buf_cnt == 2'd0) && inflight;
  assign m_valid     = (buf_cnt != 2'd0) || inflight;
  assign m_data      = head_bypass ? fifo_rd_data : buf_data[0];
  assign head_sop    = head_bypass ? inflight_sop : buf_sop[0];
  assign head_eop    = head_bypass ? inflight_eop : buf_eop[0];
  assign m_sop       = m_valid && head_sop;
  assign m_eop       = m_valid && head_eop;
  assign busy        = (state != IDLE);

  assign pop     = m_valid && m_ready;
  // The arriving word is stored unless it was consumed directly via bypass.
  assign store   = inflight && !(pop && head_bypass);
  assign pop_buf = pop && (buf_cnt != 2'd0);

  assign full_go = (state == IDLE) && (fifo_data_avail >= BLEN_FULL);

`ifdef FBR_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYC);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_arm;

  assign tmo_arm = (state == IDLE) && (fifo_data_avail != '0) &&
                   (fifo_data_avail < BLEN_FULL);
  // A full burst takes priority; tmo_arm already excludes avail >= BURST_LEN.
  assign tmo_go  = tmo_arm && (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (tmo_arm && !tmo_go) begin
      if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + TMO_ONE;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_go = 1'b0;
`endif

  // Burst control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      issued <= '0;
      blen   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full_go) begin
            state  <= BURST;
            blen   <= BLEN_FULL;
            issued <= '0;
          end else if (tmo_go) begin
            // avail < BURST_LEN here, so avail is the min of the two.
            state  <= BURST;
            blen   <= fifo_data_avail;
            issued <= '0;
          end
        end
        BURST: begin
          if (fifo_rd_en) begin
            issued <= issued + ONE;
            if ((issued + ONE) == blen) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && head_eop) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline: tag the word while its burst index is known.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
    end else begin
      inflight     <= fifo_rd_en;
      inflight_sop <= fifo_rd_en && (issued == '0);
      inflight_eop <= fifo_rd_en && ((issued + ONE) == blen);
    end
  end

  // Output buffer. When a word arrives, buf_cnt is at most 1 because of
  // the read guard, so the store index is always 0 or 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt <= '0;
      buf_sop <= '0;
      buf_eop <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      case ({store, pop_buf})
        2'b10: begin
          buf_data[buf_cnt[0]] <= fifo_rd_data;
          buf_sop[buf_cnt[0]]  <= inflight_sop;
          buf_eop[buf_cnt[0]]  <= inflight_eop;
          buf_cnt              <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_data[0] <= buf_data[1];
          buf_sop[0]  <= buf_sop[1];
          buf_eop[0]  <= buf_eop[1];
          buf_cnt     <= buf_cnt - 2'd1;
        end
        2'b11: begin
          // Head popped and a new word arrives at once: buf_cnt stays at 1.
          buf_data[0] <= fifo_rd_data;
          buf_sop[0]  <= inflight_sop;
          buf_eop[0]  <= inflight_eop;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Testbench for fifo_burst_reader. A behavioural FIFO model feeds the DUT.
// A scoreboard queue holds the expected {data, sop, eop} words. A monitor
// compares every handshake against the scoreboard and checks these
// invariants:
//   - no read while the FIFO is empty;
//   - no read while two words are outstanding;
//   - outputs hold steady while the sink stalls;
//   - busy drops after each eop.
// Table-driven runs cover the main bursts. Hand-written sequences cover the
// timeout, empty-guard and mid-burst reset cases.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int W     = 32;
  localparam int DEPTH = 9;
  localparam int PN    = $clog2(DEPTH);
  localparam int BL    = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_rd_data = '0;
  logic [PN:0]   fifo_data_avail = '0;
  logic          fifo_empty = 1'b1;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_sop;
  logic          m_eop;
  logic          busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .F_WIDTH(W), .F_DEPTH(DEPTH), .BURST_LEN(BL), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_data_avail(fifo_data_avail), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop), .busy(busy)
  );

  // ---------------- FIFO model ----------------
  logic [W-1:0] fq[$];
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         fifo_clr = 1'b0;
  int           avail_bias = 0;   // lets avail run ahead of the stored words

  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && !fifo_empty && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_empty      <= (fq.size() == 0);
    fifo_data_avail <= (PN+1)'(fq.size() + avail_bias);
  end

  // ---------------- scoreboard / bookkeeping ----------------
  typedef struct packed {
    logic [W-1:0] data;
    logic         sop;
    logic         eop;
  } exp_t;

  typedef struct {
    int           n_words;
    logic [W-1:0] base;
    logic [15:0]  ready_pat;
    int           exp_words;
    int           chk_lat;
    int           gap;
  } vec_t;

  exp_t sb[$];
  int   rd_cyc[$];
  int   first_valid;
  int   cyc;
  int   occ_rd, occ_pop;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst_n = 1'b0; m_ready = 1'b0; wr_en = 1'b0; avail_bias = 0; fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    sb.delete(); rd_cyc.delete(); first_valid = -1;
  endtask

  task automatic write_words(int n, logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = base + W'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic release_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_until_done(logic [15:0] pat, int budget);
    int k;
    k = 0;
    while (k < budget && !(sb.size() == 0 && !busy)) begin
      m_ready = pat[k % 16];
      tick();
      k++;
    end
    check("burst_complete_in_budget", 64'(sb.size()), 0);
  endtask

  vec_t vecs[5];
  exp_t e;
  logic stall, eop_done;
  logic [W-1:0] st_data;
  logic [1:0]   st_tags;

  initial begin
    // ---------------- monitor ----------------
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          occ_rd = 0; occ_pop = 0; stall = 1'b0; eop_done = 1'b0;
        end else begin
          cyc++;
          if (fifo_rd_en) begin
            check("rd_en_while_empty", 64'(fifo_empty), 0);
            check("rd_en_with_two_outstanding", 64'(occ_rd - occ_pop >= 2), 0);
          end
          if (stall) begin
            check("stall_valid_held", 64'(m_valid), 1);
            check("stall_data_held", 64'(m_data), 64'(st_data));
            check("stall_tags_held", 64'({m_sop, m_eop}), 64'(st_tags));
          end
          if (eop_done) check("busy_low_after_eop", 64'(busy), 0);
          eop_done = 1'b0;
          if (m_valid && first_valid < 0) first_valid = cyc;
          if (fifo_rd_en && !fifo_empty) rd_cyc.push_back(cyc);
          if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_word", 64'(m_data), 64'hDEAD_0000_0000);
            end else begin
              e = sb.pop_front();
              $display("word data=%08h sop=%0d eop=%0d (exp %08h %0d %0d)",
                       m_data, m_sop, m_eop, e.data, e.sop, e.eop);
              check("word_data", 64'(m_data), 64'(e.data));
              check("word_sop", 64'(m_sop), 64'(e.sop));
              check("word_eop", 64'(m_eop), 64'(e.eop));
            end
            occ_pop++;
            eop_done = m_eop;
          end
          if (fifo_rd_en && !fifo_empty) occ_rd++;
          stall   = m_valid && !m_ready;
          st_data = m_data;
          st_tags = {m_sop, m_eop};
        end
      end
    join_none

    // ---------------- vector table ----------------
    vecs[0] = '{4, 32'hA0, 16'hFFFF, 4, 1, 0};
    vecs[1] = '{4, 32'hB0, 16'hFF69, 4, 0, 0};   // ready 1,0,0,1,0,1,1,...
    vecs[2] = '{8, 32'hC0, 16'hFFFF, 8, 1, 6};
`ifdef FBR_TMO_EN
    vecs[3] = '{6, 32'hD0, 16'hFFFF, 6, 1, 0};
`else
    vecs[3] = '{6, 32'hD0, 16'hFFFF, 4, 1, 0};
`endif
    vecs[4] = '{8, 32'hE0, 16'h5A3D, 8, 0, 0};

    // ---------------- reset values ----------------
    #2 rst_n = 1'b0;
    #1;
    check("reset_rd_en", 64'(fifo_rd_en), 0);
    check("reset_m_valid", 64'(m_valid), 0);
    check("reset_m_sop", 64'(m_sop), 0);
    check("reset_m_eop", 64'(m_eop), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_m_data", 64'(m_data), 0);

    // ---------------- table-driven bursts ----------------
    for (int v = 0; v < 5; v++) begin
      apply_reset();
      write_words(vecs[v].n_words, vecs[v].base);
      for (int i = 0; i < vecs[v].exp_words; i++)
        sb.push_back('{vecs[v].base + W'(i), (i % BL) == 0,
                       ((i % BL) == BL-1) || (i == vecs[v].exp_words-1)});
      release_reset();
      run_until_done(vecs[v].ready_pat, 400);
      if (vecs[v].chk_lat != 0) begin
        check("enough_reads_logged", 64'(rd_cyc.size() >= 4), 1);
        if (rd_cyc.size() >= 4) begin
          check("reads_back_to_back", 64'(rd_cyc[3] - rd_cyc[0]), 3);
          check("first_valid_latency", 64'(first_valid - rd_cyc[0]), 1);
        end
      end
      if (vecs[v].gap != 0) begin
        check("second_burst_logged", 64'(rd_cyc.size() >= 5), 1);
        if (rd_cyc.size() >= 5)
          check("inter_burst_gap", 64'(rd_cyc[4] - rd_cyc[0]), 64'(vecs[v].gap));
      end
      m_ready = 1'b1;
      repeat (30) tick();
      check("fifo_words_left", 64'(fq.size()), 64'(vecs[v].n_words - vecs[v].exp_words));
    end

    // ---------------- timeout launch of a 2-word burst ----------------
    begin
      int r;
      apply_reset();
      release_reset();
      m_ready = 1'b1;
      repeat (3) tick();
`ifdef FBR_TMO_EN
      sb.push_back('{32'hF0, 1'b1, 1'b0});
      sb.push_back('{32'hF1, 1'b0, 1'b1});
`endif
      r = -1;
      for (int k = 0; k < 60; k++) begin
        wr_en = (k < 2); wr_data = 32'hF0 + W'(k);
        tick();                              // k==0 sample: first avail != 0
        wr_en = 1'b0;
        if (fifo_rd_en && r < 0) r = k;
      end
`ifdef FBR_TMO_EN
      check("tmo_launch_delay", 64'(r == 16 || r == 17), 1);
      check("tmo_words_delivered", 64'(sb.size()), 0);
`else
      check("no_read_without_tmo", 64'(r), 64'(-1));
      check("words_stay_in_fifo", 64'(fq.size()), 2);
`endif
    end

    // ---------------- empty guard with a slow writer ----------------
    begin
      int written;
      apply_reset();
      avail_bias = 3;
      write_words(1, 32'h50);
      for (int i = 0; i < 4; i++)
        sb.push_back('{32'h50 + W'(i), i == 0, i == 3});
      release_reset();
      m_ready = 1'b1;
      written = 0;
      for (int k = 0; k < 100 && !(sb.size() == 0 && !busy); k++) begin
        if (k % 3 == 2 && written < 3) begin
          wr_en = 1'b1; wr_data = 32'h51 + W'(written);
          avail_bias = avail_bias - 1; written++;
        end
        tick();
        wr_en = 1'b0;
      end
      check("empty_guard_all_delivered", 64'(sb.size()), 0);
    end

    // ---------------- reset in the middle of a burst ----------------
    apply_reset();
    write_words(4, 32'h70);
    for (int i = 0; i < 4; i++)
      sb.push_back('{32'h70 + W'(i), i == 0, i == 3});
    release_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 50 && occ_pop < 2; k++) tick();
    check("two_words_before_reset", 64'(occ_pop), 2);
    rst_n = 1'b0;
    #1;
    check("midreset_m_valid", 64'(m_valid), 0);
    check("midreset_m_sop", 64'(m_sop), 0);
    check("midreset_m_eop", 64'(m_eop), 0);
    check("midreset_busy", 64'(busy), 0);
    check("midreset_rd_en", 64'(fifo_rd_en), 0);
    check("midreset_m_data", 64'(m_data), 0);
    sb.delete();
    m_ready = 1'b0;
    tick();
    write_words(4, 32'h80);
    tick();
    for (int i = 0; i < 4; i++)
      sb.push_back('{fq[i], i == 0, i == 3});
    release_reset();
    run_until_done(16'hFFFF, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
